sync_multi: RTL and testbench

- Parametrised multi-channel synchroniser with reset-value control, configurable chain depth and per-channel edge detection.
- Brings WIDTH independent asynchronous inputs (buttons, external strobes, cross-domain flags) into the clk domain.
- Supplies single-cycle rise and fall pulses so downstream FSMs need no private edge detectors.
- Optional per-channel stability filter suppresses short glitches.

---
 rtl/sync_multi.sv | 100 ++++++++++
 tb/tb_sync_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_multi.sv
// sync_multi: WIDTH-channel asynchronous-input synchroniser with per-channel
// rise/fall pulse decode. Each channel passes through a STAGES-deep flop chain.
// Optional glitch filter is enabled by defining SYNC_FILTER_EN: a new level
// must persist FILT_LEN cycles at the chain output before it is accepted.
module sync_multi #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int unsigned      FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    generate
        if (STAGES < 2) begin : g_stages_chk
            $error("sync_multi: STAGES must be >= 2");
        end
        if (FILT_LEN < 1) begin : g_filt_chk
            $error("sync_multi: FILT_LEN must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]             chain_out;
    logic [WIDTH-1:0]             hist_q;

    // Synchroniser chain: stage 0 samples the raw inputs, later stages shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_in};
        end
    end

    assign chain_out = chain_q[STAGES-1];

`ifdef SYNC_FILTER_EN
    localparam int unsigned   CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [WIDTH-1:0]          filt_q;
    logic [WIDTH-1:0]          filt_d;
    logic [WIDTH-1:0][CW-1:0]  cnt_q;
    logic [WIDTH-1:0][CW-1:0]  cnt_d;

    // Per-channel persistence counter: accept a new level only after it has
    // been seen FILT_LEN consecutive cycles; any return to filt_q restarts.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (chain_out[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = chain_out[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            filt_q <= RST_VAL;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_out = filt_q;
`else
    assign sync_out = chain_out;
`endif

    // Edge history: previous cycle's synchronised level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= RST_VAL;
        end else begin
            hist_q <= sync_out;
        end
    end

    // Both operands are registered, so the decoded pulses are glitch-free.
    assign rise_pulse = sync_out & ~hist_q;
    assign fall_pulse = ~sync_out & hist_q;
    assign any_change = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_multi.sv
// tb_sync_multi: directed bench for sync_multi. Instance A: STAGES=2,
// RST_VAL=4'b0101. Instance B: STAGES=3, RST_VAL=0. Filter vectors run only
// when SYNC_FILTER_EN is defined.
module tb_sync_multi;

`ifdef SYNC_FILTER_EN
    localparam int FLT = 4;
`else
    localparam int FLT = 0;
`endif
    localparam int LAT_A = 2 + FLT;
    localparam int LAT_B = 3 + FLT;

    logic       clk;
    logic       n_rst;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic       any_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;
    logic       any_b;

    int checks = 0;
    int errors = 0;

    sync_multi #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0101), .FILT_LEN(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .async_in(in_a), .sync_out(out_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a)
    );

    sync_multi #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0000), .FILT_LEN(4)) dut_b (
        .clk(clk), .n_rst(n_rst), .async_in(in_b), .sync_out(out_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                           input logic [3:0] f, input logic a);
        check({tag, "_out"},  out_a,  o);
        check({tag, "_rise"}, rise_a, r);
        check({tag, "_fall"}, fall_a, f);
        check({tag, "_any"},  any_a,  a);
    endtask

    initial begin
        int nrise;
        int nfall;
        n_rst = 1'b1;
        in_a  = 4'hF;
        in_b  = 4'h0;
        #1 n_rst = 1'b0;

        // Reset value held during reset
        #1;
        check_a("rst_async", 4'b0101, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_a("rst_hold", 4'b0101, 4'h0, 4'h0, 1'b0);
            check("rst_b_out", out_b, 4'h0);
        end

        // Release: all-ones reaches sync_out after LAT_A edges
        n_rst = 1'b1;
        for (int e = 1; e <= LAT_A; e++) begin
            tick;
            if (e < LAT_A) check_a("rel_pre", 4'b0101, 4'h0, 4'h0, 1'b0);
            else           check_a("rel_edge", 4'hF, 4'b1010, 4'h0, 1'b1);
        end
        tick;
        check_a("rel_post", 4'hF, 4'h0, 4'h0, 1'b0);

        // Latency on the 3-stage instance
        @(negedge clk);
        in_b = 4'b0001;
        for (int e = 1; e <= LAT_B + 1; e++) begin
            tick;
            check("lat_out",  out_b,  (e >= LAT_B) ? 4'b0001 : 4'b0000);
            check("lat_rise", rise_b, (e == LAT_B) ? 4'b0001 : 4'b0000);
            check("lat_fall", fall_b, 4'h0);
            check("lat_any",  any_b,  (e == LAT_B) ? 1'b1 : 1'b0);
        end

        // Simultaneous opposite edges
        in_a = 4'b0011;
        for (int e = 0; e <= LAT_A + 1; e++) tick;
        check_a("sim_base", 4'b0011, 4'h0, 4'h0, 1'b0);
        in_a = 4'b1100;
        for (int e = 1; e <= LAT_A + 1; e++) begin
            tick;
            if (e < LAT_A)       check_a("sim_pre",  4'b0011, 4'h0, 4'h0, 1'b0);
            else if (e == LAT_A) check_a("sim_edge", 4'b1100, 4'b1100, 4'b0011, 1'b1);
            else                 check_a("sim_post", 4'b1100, 4'h0, 4'h0, 1'b0);
        end

`ifndef SYNC_FILTER_EN
        // Toggle ch2 every cycle for 8 cycles: falls at edges 2,4,6,8; rises 3,5,7,9
        nrise = 0;
        nfall = 0;
        in_a[2] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick;
            check("tog_rise", rise_a, (c >= 3 && c <= 9 && (c % 2) == 1) ? 4'b0100 : 4'b0000);
            check("tog_fall", fall_a, (c >= 2 && c <= 8 && (c % 2) == 0) ? 4'b0100 : 4'b0000);
            if (rise_a[2]) nrise++;
            if (fall_a[2]) nfall++;
            if (c < 8) in_a[2] = ~in_a[2];
        end
        check("tog_nrise", nrise, 4);
        check("tog_nfall", nfall, 4);

        // Mid-operation reset while toggling
        in_a[2] = 1'b0;
        tick;
        in_a[2] = 1'b1;
        tick;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_a("mid_rst", 4'b0101, 4'h0, 4'h0, 1'b0);
        in_a = 4'b0101;
        tick;
        check_a("mid_hold", 4'b0101, 4'h0, 4'h0, 1'b0);
        tick;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check_a("mid_rel", 4'b0101, 4'h0, 4'h0, 1'b0);
        end
        in_a = 4'b1101;
        tick;
        check_a("mid_new_pre", 4'b0101, 4'h0, 4'h0, 1'b0);
        tick;
        check_a("mid_new", 4'b1101, 4'b1000, 4'h0, 1'b1);
`else
        nrise = 0;
        nfall = 0;
        // 2-cycle glitch on ch1 is suppressed
        in_a[1] = 1'b1;
        tick;
        tick;
        in_a[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check_a("flt_glitch", 4'b1100, 4'h0, 4'h0, 1'b0);
        end
        // Held level accepted at edge STAGES+4
        in_a[1] = 1'b1;
        for (int e = 1; e <= LAT_A + 1; e++) begin
            tick;
            if (e < LAT_A)       check_a("flt_pre",  4'b1100, 4'h0, 4'h0, 1'b0);
            else if (e == LAT_A) check_a("flt_edge", 4'b1110, 4'b0010, 4'h0, 1'b1);
            else                 check_a("flt_post", 4'b1110, 4'h0, 4'h0, 1'b0);
            if (rise_a[1]) nrise++;
        end
        check("flt_nrise", nrise, 1);
        // 3-cycle low dip is suppressed
        in_a[1] = 1'b0;
        tick;
        tick;
        tick;
        in_a[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check_a("flt_dip", 4'b1110, 4'h0, 4'h0, 1'b0);
            if (fall_a[1]) nfall++;
        end
        check("flt_nfall", nfall, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
